// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default sizing constants and word/address types for the ARM register file (no ports)
package reg_file_pkg;
  localparam int DATA_W      = 32;
  localparam int NUM_REGS    = 16;
  localparam int ADDR_W      = 4;
  localparam int NUM_RD      = 3;
  localparam int PC_IDX      = 15;
  localparam int PC_INC      = 4;
  localparam int PC_READ_OFS = 8;
  localparam int RESET_PC    = 0;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/reg_file_pc_ctr.sv
// reg_file_pc_ctr: PC register with priority reset > PC-index write > pc_ld > pc_inc > hold; ports clk, reset, we/wr_addr/wr_data, pc_ld/pc_in, pc_inc -> pc_q
module reg_file_pc_ctr import reg_file_pkg::*; #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int PC_IDX   = reg_file_pkg::PC_IDX,
  parameter int PC_INC   = reg_file_pkg::PC_INC,
  parameter int RESET_PC = reg_file_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_ld,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc_q
);
  localparam bit PC_VIS = PC_IDX < NUM_REGS;
  logic [DATA_W-1:0] pc_d;
  logic              pc_wr;
  always_comb begin
    pc_wr = PC_VIS && we && wr_addr == ADDR_W'(PC_IDX);
    pc_d  = pc_wr  ? {wr_data[DATA_W-1:2], 2'b00} :
            pc_ld  ? {pc_in[DATA_W-1:2], 2'b00} :
            pc_inc ? pc_q + DATA_W'(PC_INC) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) pc_q <= DATA_W'(RESET_PC);
    else pc_q <= pc_d;
  end
endmodule

// File: rtl/arm_reg_file_mp.sv
// arm_reg_file_mp: ARM register file, NUM_RD comb reads (rd_addr->rd_data), one sync write (we/wr_addr/wr_data), PC ctrl (pc_ld/pc_in/pc_inc->pc_out), clk/reset; REG_FILE_BYPASS_EN enables write-first forwarding
module arm_reg_file_mp import reg_file_pkg::*; #(
  parameter int DATA_W      = reg_file_pkg::DATA_W,
  parameter int NUM_REGS    = reg_file_pkg::NUM_REGS,
  parameter int ADDR_W      = reg_file_pkg::ADDR_W,
  parameter int NUM_RD      = reg_file_pkg::NUM_RD,
  parameter int PC_IDX      = reg_file_pkg::PC_IDX,
  parameter int PC_INC      = reg_file_pkg::PC_INC,
  parameter int PC_READ_OFS = reg_file_pkg::PC_READ_OFS,
  parameter int RESET_PC    = reg_file_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_ld,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc_out
);
  localparam bit PC_VIS = PC_IDX < NUM_REGS;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_rd;
  logic              wr_ok;
  assign wr_ok  = we && int'(wr_addr) < NUM_REGS && !(PC_VIS && wr_addr == ADDR_W'(PC_IDX));
  assign pc_rd  = pc_q + DATA_W'(PC_READ_OFS);
  assign pc_out = pc_q;
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = (wr_ok && int'(wr_addr) == r) ? wr_data : regs_q[r];
  end
  always_ff @(posedge clk) begin
    if (reset) for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    else regs_q <= regs_d;
  end
  reg_file_pc_ctr #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .PC_IDX(PC_IDX), .PC_INC(PC_INC), .RESET_PC(RESET_PC)
  ) u_pc (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_ld(pc_ld), .pc_in(pc_in), .pc_inc(pc_inc), .pc_q(pc_q)
  );
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] gpr;
    logic              fwd;
    assign a   = rd_addr[i*ADDR_W +: ADDR_W];
    assign gpr = int'(a) < NUM_REGS ? regs_q[a] : '0;
`ifdef REG_FILE_BYPASS_EN
    assign fwd = wr_ok && wr_addr == a;
`else
    assign fwd = 1'b0;
`endif
    assign rd_data[i*DATA_W +: DATA_W] = (PC_VIS && a == ADDR_W'(PC_IDX)) ? pc_rd : fwd ? wr_data : gpr;
  end
endmodule

// File: tb/tb_arm_reg_file_mp.sv
// tb_arm_reg_file_mp: directed plus random checks of arm_reg_file_mp against an array-based reference model
module tb_arm_reg_file_mp;
  import reg_file_pkg::*;
  logic        clk = 0;
  logic        reset;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        we;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_ld;
  logic [31:0] pc_in;
  logic        pc_inc;
  logic [31:0] pc_out;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_r [16];
  logic [31:0] m_pc;
  arm_reg_file_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_ld(pc_ld), .pc_in(pc_in), .pc_inc(pc_inc), .pc_out(pc_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return m_pc + 32'd8;
`ifdef REG_FILE_BYPASS_EN
    if (we && wr_addr == a) return wr_data;
`endif
    return m_r[a];
  endfunction
  task automatic check_reads(input string tag);
    for (int p = 0; p < 3; p++)
      chk($sformatf("%s rd%0d a=%0d", tag, p, rd_addr[p*4 +: 4]), rd_data[p*32 +: 32], exp_rd(rd_addr[p*4 +: 4]));
  endtask
  task automatic step();
    if (reset) begin
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      m_pc = 0;
    end else begin
      if (we && wr_addr != 4'd15) m_r[wr_addr] = wr_data;
      if (we && wr_addr == 4'd15) m_pc = wr_data & 32'hFFFF_FFFC;
      else if (pc_ld) m_pc = pc_in & 32'hFFFF_FFFC;
      else if (pc_inc) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reset = 0; we = 0; wr_addr = 0; wr_data = 0; pc_ld = 0; pc_in = 0; pc_inc = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) m_r[i] = 'x;
    m_pc = 'x;
    idle();
    reset = 1;
    rd_addr = {4'd15, 4'd5, 4'd0};
    #2;
    step();
    chk("reset pc_out", pc_out, 32'h0);
    chk("reset rd0", rd_data[31:0], 32'h0);
    chk("reset rd1", rd_data[63:32], 32'h0);
    chk("reset rd2", rd_data[95:64], 32'h8);
    idle();
    for (int i = 0; i < 15; i++) begin
      we = 1; wr_addr = 4'(i); wr_data = 32'hF0F0_F0F0 ^ 32'(i);
      step();
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      rd_addr = {4'(i), 4'(i), 4'(i)};
      #1;
      for (int p = 0; p < 3; p++)
        chk($sformatf("gpr r%0d port%0d", i, p), rd_data[p*32 +: 32], 32'hF0F0_F0F0 ^ 32'(i));
    end
    rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    chk("r15 untouched by gpr writes", rd_data[31:0], 32'h8);
    chk("pc held", pc_out, 32'h0);
    pc_ld = 1; pc_in = 32'hFFFF_FFF8;
    step();
    idle();
    chk("pc load", pc_out, 32'hFFFF_FFF8);
    pc_inc = 1;
    step();
    chk("pc inc 1", pc_out, 32'hFFFF_FFFC);
    chk("r15 read wraps", rd_data[95:64], 32'h0000_0004);
    step();
    chk("pc inc wrap", pc_out, 32'h0);
    idle();
    we = 1; wr_addr = 15; wr_data = 32'h0000_1003; pc_ld = 1; pc_in = 32'h2000; pc_inc = 1;
    step();
    idle();
    chk("pc priority write", pc_out, 32'h0000_1000);
    pc_ld = 1; pc_in = 32'h0000_3007; pc_inc = 1;
    step();
    idle();
    chk("pc ld beats inc", pc_out, 32'h0000_3004);
    we = 1; wr_addr = 3; wr_data = 32'hAAAA_AAAA;
    step();
    wr_data = 32'h5555_5555;
    rd_addr = {4'd3, 4'd3, 4'd3};
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("same-cycle r3", rd_data[31:0], 32'h5555_5555);
`else
    chk("same-cycle r3", rd_data[31:0], 32'hAAAA_AAAA);
`endif
    step();
    idle();
    chk("r3 after edge", rd_data[63:32], 32'h5555_5555);
    we = 1; wr_addr = 7; wr_data = 32'h1234_5678; pc_ld = 1; pc_in = 32'h40;
    step();
    idle();
    rd_addr = {4'd15, 4'd7, 4'd7};
    #1;
    chk("r7 before reset", rd_data[31:0], 32'h1234_5678);
    chk("pc before reset", pc_out, 32'h40);
    reset = 1; we = 1; wr_addr = 7; wr_data = 32'hDEAD_BEEF; pc_ld = 1; pc_in = 32'h80;
    step();
    idle();
    chk("r7 after reset", rd_data[63:32], 32'h0);
    chk("pc after reset", pc_out, 32'h0);
    chk("r15 after reset", rd_data[95:64], 32'h8);
    for (int c = 0; c < 300; c++) begin
      reset   = ($urandom_range(0, 31) == 0);
      we      = $urandom_range(0, 1);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      pc_ld   = ($urandom_range(0, 7) == 0);
      pc_in   = $urandom;
      pc_inc  = $urandom_range(0, 1);
      rd_addr = {4'($urandom_range(0, 15)), (c % 4 == 0) ? wr_addr : 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      #1;
      check_reads($sformatf("rand c%0d", c));
      chk($sformatf("rand pc c%0d", c), pc_out, m_pc);
      step();
    end
    idle();
    #1;
    chk("final pc", pc_out, m_pc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arm_reg_file_mp.md
Name: arm_reg_file_mp

Overview:
- Parametrised, multi-read-port ARM register file. Successor to the fixed 16x32, two-read-port file.
- Holds NUM_REGS general registers. One index (PC_IDX) is a dedicated program-counter register that auto-increments.
- Provides NUM_RD combinational read ports, one synchronous write port, and PC load/increment control.
- Sits between the decode stage (register addresses) and the ALU/shifter operand buses. Feeds the fetch-address mux from pc_out.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, number of architectural registers including PC
ADDR_W, 4, register index width; must satisfy 2**ADDR_W >= NUM_REGS
NUM_RD, 3, number of read ports
PC_IDX, 15, register index mapped to the PC
PC_INC, 4, PC increment per pc_inc cycle
PC_READ_OFS, 8, offset added to the PC when it is read through a read port (ARM pipeline view)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
we  in  1  write enable
wr_addr  in  ADDR_W  write index
wr_data  in  DATA_W  write data
pc_ld  in  1  load PC from pc_in
pc_in  in  DATA_W  PC load value
pc_inc  in  1  advance PC by PC_INC
pc_out  out  DATA_W  current PC register value (fetch address)

Behaviour:
- Reset: on a rising clk edge with reset=1, all general registers become 0 and the PC becomes RESET_PC. Reset overrides every other input in that cycle.
- Values after reset: pc_out=RESET_PC. rd_data port i = 0, except a port addressing PC_IDX returns RESET_PC+PC_READ_OFS.
- Reads: purely combinational from rd_addr and register state, zero latency.
  - Address == PC_IDX: returns (pc + PC_READ_OFS) mod 2**DATA_W.
  - Address >= NUM_REGS: returns 0.
  - Write-then-read in the same cycle returns the OLD value unless REG_FILE_BYPASS_EN is defined.
- GPR write: at the rising edge, if we=1, wr_addr != PC_IDX and wr_addr < NUM_REGS, then reg[wr_addr] <= wr_data.
  - we with wr_addr >= NUM_REGS is silently ignored.
- PC update at the rising edge, in strict priority order:
  1. reset -> RESET_PC
  2. we=1 and wr_addr==PC_IDX -> {wr_data[DATA_W-1:2], 2'b00} (branch by register write)
  3. pc_ld=1 -> {pc_in[DATA_W-1:2], 2'b00}
  4. pc_inc=1 -> pc + PC_INC, wrapping modulo 2**DATA_W (0xFFFFFFFC + 4 -> 0x00000000)
  5. otherwise hold
- Simultaneous events:
  - A PC-index write and pc_ld in the same cycle: the write wins; pc_ld is dropped with no error flag.
  - pc_ld together with pc_inc: the load wins.
- All GPRs and the PC are plain registers with no internal FSM. Ports must be legal for any NUM_RD >= 1.
- Parameter elaboration check: if PC_IDX >= NUM_REGS, the PC is unreachable by reads/writes but still drives pc_out.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: any read port whose address equals wr_addr while we=1 returns wr_data (write-first forwarding). This applies only when wr_addr != PC_IDX and wr_addr < NUM_REGS. PC-index reads are never forwarded.
- Not defined: reads always show pre-edge register contents.

Decomposition:
- Package reg_file_pkg holds:
  - default constants DATA_W, NUM_REGS, ADDR_W, PC_IDX, PC_INC, PC_READ_OFS
  - typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_word_t (logic [DATA_W-1:0])
- One sub-module, reg_file_pc_ctr: PC register, priority logic, alignment and increment. Top level holds the GPR array, write decode, and a generate loop of read muxes.

Test Plan:
- Reset: hold reset=1 one edge with rd_addr={0,5,15} -> rd_data={0,0,8}, pc_out=0.
- Write/read all GPRs: write 0xF0F0F0F0^i to r0..r14, then read via all three ports -> each returns the written value; r15 is unaffected by data until a PC write.
- PC increment and wrap: pc_ld pc_in=0xFFFFFFF8, then pc_inc for 2 cycles -> pc_out 0xFFFFFFFC, then 0x00000000. Read r15 after the first increment -> 0x00000004.
- PC priority: same edge with we=1, wr_addr=15, wr_data=0x00001003, pc_ld=1, pc_in=0x2000, pc_inc=1 -> pc_out=0x00001000.
- Same-cycle read/write on r3 (old 0xAAAAAAAA, new 0x55555555): read returns 0xAAAAAAAA before the edge without REG_FILE_BYPASS_EN, 0x55555555 with it. After the edge both builds return 0x55555555.
- Mid-operation reset: r7=0x12345678, pc=0x40, assert reset with we=1 to r7 -> r7=0 and pc_out=RESET_PC; the write is discarded.
